dmem_dump_arbiter: RTL and testbench
====================================

# dmem_dump_arbiter

Arbiter and scan sequencer for the single data-RAM port of the Harvard MIPS system. It passes the CPU data port straight through to the data RAM until a dump is requested. It then takes ownership of the port and walks a word-aligned address range, presenting each word big-endian on a valid/ready stream. It sits between `mips_cpu_harvard` and the data RAM, and replaces the ad-hoc address/read muxing in benches and the debug path.

## Interface
- `PREEMPT`, default 0: 1 = a dump issued while the CPU is active stalls the CPU via `cpu_clk_enable` and scans immediately; 0 = the dump waits for `cpu_active` low.
- `COUNT_W`, default 8: width of the word-count field; max dump length is 2^COUNT_W−1 words.
- `clk` in 1: system clock; single clock domain.
- `reset` in 1: synchronous, active-high.
- `cpu_active` in 1: CPU `active` output.
- `cpu_clk_enable` out 1: drives CPU `clk_enable`.
- `cpu_address` in 32: CPU data address.
- `cpu_read` in 1: CPU data read strobe.
- `cpu_write` in 1: CPU data write strobe.
- `cpu_writedata` in 32: CPU write data.
- `cpu_readdata` out 32: read data returned to the CPU.
- `mem_address` out 32: data RAM address.
- `mem_read` out 1: data RAM read strobe.
- `mem_write` out 1: data RAM write strobe.
- `mem_writedata` out 32: data RAM write data.
- `mem_readdata` in 32: data RAM read data; combinational read, little-endian byte order.
- `dump_start` in 1: one-cycle request to begin a dump.
- `dump_base` in 32: byte address of the first word.
- `dump_count` in COUNT_W: number of words to dump.
- `dump_valid` out 1: current dump word is valid.
- `dump_ready` in 1: consumer accepts the current word.
- `dump_addr` out 32: address of the current word.
- `dump_data` out 32: current word, byte-reversed to big-endian.
- `dump_busy` out 1: high in every state except IDLE.
- `dump_done` out 1: one-cycle pulse at the end of a dump.

## Operation
- FSM states: IDLE, WAIT_HALT, SCAN, DONE.
- IDLE, pass-through:
  - `mem_*` equal the `cpu_*` inputs.
  - `cpu_clk_enable` = 1.
  - `dump_valid` = 0.
- IDLE with `dump_start`:
  - Latch `ptr` = {`dump_base`[31:2], 2'b00} and `remaining` = `dump_count`.
  - If `dump_count` == 0, go to DONE.
  - Otherwise, if `cpu_active` && !PREEMPT, go to WAIT_HALT.
  - Otherwise go to SCAN.
- WAIT_HALT: pass-through continues; go to SCAN on the first cycle with `cpu_active` == 0.
- SCAN, port ownership:
  - `mem_address` = `ptr`, `mem_read` = 1, `mem_write` = 0.
  - `cpu_clk_enable` = 0; CPU writes are dropped, which is harmless because the CPU is stalled.
- SCAN, stream outputs:
  - `dump_valid` = 1, `dump_addr` = `ptr`.
  - `dump_data` = {`mem_readdata`[7:0], [15:8], [23:16], [31:24]}.
- SCAN, handshake:
  - `dump_valid` && `dump_ready`: `ptr` += 4 (32-bit wrap, 0xFFFFFFFC → 0x0), `remaining` −= 1.
  - Acceptance with `remaining` == 1 goes to DONE.
  - `!dump_ready`: hold `ptr`, `remaining` and all outputs stable.
- DONE: `dump_done` = 1 and pass-through for one cycle, then IDLE.
- `dump_start` is ignored outside IDLE.
- `cpu_readdata` = `mem_readdata` in all states.

## Timing
- Reset, effective at the first `clk` edge with `reset` = 1:
  - State goes to IDLE; `ptr` and `remaining` clear to 0.
  - Outputs: `dump_valid`/`dump_busy`/`dump_done` = 0, `cpu_clk_enable` = 1, `mem_*` = pass-through.
- Reset mid-scan aborts without a `dump_done` pulse.
- `mem_*`, `cpu_clk_enable` and `dump_*` are combinational from registered state plus inputs. There are no extra pipeline stages.
- Latency:
  - `dump_start` to first `dump_valid` is 1 cycle when PREEMPT, or when the CPU is already halted.
  - In WAIT_HALT, the first `dump_valid` comes 1 cycle after `cpu_active` falls.
- Throughput: 1 word per cycle while `dump_ready` = 1.
- N words with ready held high: SCAN lasts N cycles, and `dump_done` is asserted in cycle N+1 after SCAN entry.
- `dump_count` == 0: `dump_done` 1 cycle after `dump_start`, no `dump_valid`.

## Structure
- Shared package `mips_dbg_pkg`:
  - `dump_state_t` enum.
  - `reverse_endian` function, also used by benches.
  - `WORD_BYTES` = 4 constant.
- Sub-module `dump_addr_counter` holds `ptr` and `remaining`, with load/advance/last outputs.
- The FSM and the port mux stay in the top module.

## Test plan
- CPU runs to halt, then `dump_start` with base 0x100, count 29, ready held 1 → 29 beats, `dump_addr` 0x100..0x170 step 4, `dump_data` = big-endian RAM contents, `dump_done` on cycle 30.
- Ready toggled 1,0,0,1 over a 3-word dump at 0x40 → each word held stable during stalls, addresses 0x40/0x44/0x48 each accepted exactly once.
- PREEMPT=1, `dump_start` while `cpu_active` = 1 → `cpu_clk_enable` low exactly during SCAN, CPU PC unchanged across the dump, CPU resumes and reaches the same `register_v0`.
- PREEMPT=0, `dump_start` while active → `dump_busy` = 1 with no `dump_valid` until `cpu_active` falls, then scan.
- Base 0xFFFFFFF8 (also 0xFFFFFFFB, to check alignment), count 3 → addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000; count 0 → `dump_done` with no beats.
- `reset` asserted mid-scan on beat 5 → next cycle IDLE, pass-through restored, no `dump_done`; a new `dump_start` then works normally.

Source files
------------

// File: rtl/mips_dbg_pkg.sv
// Shared debug types for the Harvard MIPS system: dump sequencer states,
// the word size and the little-to-big-endian byte swap.
package mips_dbg_pkg;

    localparam int WORD_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_HALT,
        SCAN,
        DONE
    } dump_state_t;

    function automatic logic [31:0] reverse_endian(input logic [31:0] word);
        return {word[7:0], word[15:8], word[23:16], word[31:24]};
    endfunction

endpackage

// File: rtl/dump_addr_counter.sv
// Word pointer and remaining-word counter for the dump scan.
// The pointer is always word aligned and wraps at the top of the address space.
module dump_addr_counter
    import mips_dbg_pkg::*;
#(
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               advance,
    input  logic [29:0]        base_word,
    input  logic [COUNT_W-1:0] count,
    output logic [31:0]        ptr,
    output logic               last
);

    logic [COUNT_W-1:0] remaining;

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr       <= '0;
            remaining <= '0;
        end else if (load) begin
            ptr       <= {base_word, 2'b00};
            remaining <= count;
        end else if (advance) begin
            ptr       <= ptr + 32'(WORD_BYTES);
            remaining <= remaining - COUNT_W'(1);
        end
    end

    assign last = (remaining == COUNT_W'(1));

endmodule

// File: rtl/dmem_dump_arbiter.sv
// Data-RAM port arbiter: passes the CPU through until a dump is requested,
// then owns the port and streams a word range out big-endian on valid/ready.
module dmem_dump_arbiter
    import mips_dbg_pkg::*;
#(
    parameter bit PREEMPT = 1'b0,
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cpu_active,
    output logic               cpu_clk_enable,
    input  logic [31:0]        cpu_address,
    input  logic               cpu_read,
    input  logic               cpu_write,
    input  logic [31:0]        cpu_writedata,
    output logic [31:0]        cpu_readdata,
    output logic [31:0]        mem_address,
    output logic               mem_read,
    output logic               mem_write,
    output logic [31:0]        mem_writedata,
    input  logic [31:0]        mem_readdata,
    input  logic               dump_start,
    input  logic [31:0]        dump_base,
    input  logic [COUNT_W-1:0] dump_count,
    output logic               dump_valid,
    input  logic               dump_ready,
    output logic [31:0]        dump_addr,
    output logic [31:0]        dump_data,
    output logic               dump_busy,
    output logic               dump_done
);

    dump_state_t state;
    logic [31:0] ptr;
    logic        last;
    logic        load;
    logic        advance;
    logic        scanning;

    assign scanning = (state == SCAN);
    assign load     = (state == IDLE) && dump_start;
    assign advance  = scanning && dump_ready;

    dump_addr_counter #(
        .COUNT_W(COUNT_W)
    ) u_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .advance  (advance),
        .base_word(dump_base[31:2]),
        .count    (dump_count),
        .ptr      (ptr),
        .last     (last)
    );

    // busy covers every non-IDLE state; done is a single-cycle flag for DONE
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            dump_busy <= 1'b0;
            dump_done <= 1'b0;
        end else begin
            dump_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (dump_start) begin
                        dump_busy <= 1'b1;
                        if (dump_count == '0) begin
                            state     <= DONE;
                            dump_done <= 1'b1;
                        end else if (cpu_active && !PREEMPT) begin
                            state <= WAIT_HALT;
                        end else begin
                            state <= SCAN;
                        end
                    end
                end
                WAIT_HALT: begin
                    if (!cpu_active) state <= SCAN;
                end
                SCAN: begin
                    if (dump_ready && last) begin
                        state     <= DONE;
                        dump_done <= 1'b1;
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    dump_busy <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    dump_busy <= 1'b0;
                end
            endcase
        end
    end

    // CPU writes are dropped while scanning; the CPU is stalled then anyway
    assign mem_address    = scanning ? ptr : cpu_address;
    assign mem_read       = scanning ? 1'b1 : cpu_read;
    assign mem_write      = scanning ? 1'b0 : cpu_write;
    assign mem_writedata  = cpu_writedata;
    assign cpu_readdata   = mem_readdata;
    assign cpu_clk_enable = !scanning;

    assign dump_valid = scanning;
    assign dump_addr  = ptr;
    assign dump_data  = reverse_endian(mem_readdata);

endmodule

// File: tb/tb_dmem_dump_arbiter.sv
// Bench for dmem_dump_arbiter: a wait-for-halt instance and a preempting
// instance share stimulus and are checked against a queue-based model.
module tb_dmem_dump_arbiter;

    logic        clk;
    logic        reset;
    logic        cpu_active;
    logic [31:0] cpu_address;
    logic        cpu_read;
    logic        cpu_write;
    logic [31:0] cpu_writedata;
    logic        dump_start;
    logic [31:0] dump_base;
    logic [7:0]  dump_count;
    logic        dump_ready;

    logic        clk_en_w     [2];
    logic [31:0] cpu_rdata_w  [2];
    logic [31:0] mem_addr_w   [2];
    logic        mem_rd_w     [2];
    logic        mem_wr_w     [2];
    logic [31:0] mem_wdata_w  [2];
    logic [31:0] mem_rdata_w  [2];
    logic        valid_w      [2];
    logic [31:0] addr_w       [2];
    logic [31:0] data_w       [2];
    logic        busy_w       [2];
    logic        done_w       [2];

    int checks   = 0;
    int failures = 0;

    // model: words still to deliver per instance, plus halt-wait and done flags
    logic [31:0] m_q [2][$];
    bit          m_wait [2];
    bit          m_done [2];
    bit          model_live = 0;

    int          beats;
    int          beats1;
    int          done_at;
    int          lows;
    int          v0;
    int          acc_n;
    logic [31:0] acc [8];
    bit          pat [8];

    function automatic logic [31:0] ram_word(input logic [31:0] a);
        return a ^ 32'h1234_5678;
    endfunction

    function automatic logic [31:0] to_big(input logic [31:0] w);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[8*b +: 8] = w[8*(3-b) +: 8];
        return r;
    endfunction

    assign mem_rdata_w[0] = ram_word(mem_addr_w[0]);
    assign mem_rdata_w[1] = ram_word(mem_addr_w[1]);

    dmem_dump_arbiter #(.PREEMPT(1'b0), .COUNT_W(8)) dut0 (
        .clk(clk), .reset(reset), .cpu_active(cpu_active), .cpu_clk_enable(clk_en_w[0]),
        .cpu_address(cpu_address), .cpu_read(cpu_read), .cpu_write(cpu_write),
        .cpu_writedata(cpu_writedata), .cpu_readdata(cpu_rdata_w[0]),
        .mem_address(mem_addr_w[0]), .mem_read(mem_rd_w[0]), .mem_write(mem_wr_w[0]),
        .mem_writedata(mem_wdata_w[0]), .mem_readdata(mem_rdata_w[0]),
        .dump_start(dump_start), .dump_base(dump_base), .dump_count(dump_count),
        .dump_valid(valid_w[0]), .dump_ready(dump_ready), .dump_addr(addr_w[0]),
        .dump_data(data_w[0]), .dump_busy(busy_w[0]), .dump_done(done_w[0])
    );

    dmem_dump_arbiter #(.PREEMPT(1'b1), .COUNT_W(8)) dut1 (
        .clk(clk), .reset(reset), .cpu_active(cpu_active), .cpu_clk_enable(clk_en_w[1]),
        .cpu_address(cpu_address), .cpu_read(cpu_read), .cpu_write(cpu_write),
        .cpu_writedata(cpu_writedata), .cpu_readdata(cpu_rdata_w[1]),
        .mem_address(mem_addr_w[1]), .mem_read(mem_rd_w[1]), .mem_write(mem_wr_w[1]),
        .mem_writedata(mem_wdata_w[1]), .mem_readdata(mem_rdata_w[1]),
        .dump_start(dump_start), .dump_base(dump_base), .dump_count(dump_count),
        .dump_valid(valid_w[1]), .dump_ready(dump_ready), .dump_addr(addr_w[1]),
        .dump_data(data_w[1]), .dump_busy(busy_w[1]), .dump_done(done_w[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input int inst,
                                input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s inst%0d actual=%08h expected=%08h @%0t",
                     name, inst, actual, expected, $time);
        end
    endtask

    task automatic model_step(input int i);
        bit was_idle;
        bit fin;
        if (reset) begin
            m_q[i].delete();
            m_wait[i] = 0;
            m_done[i] = 0;
            return;
        end
        was_idle = (m_q[i].size() == 0) && !m_done[i];
        fin = 0;
        if (was_idle) begin
            if (dump_start) begin
                for (int k = 0; k < int'(dump_count); k++)
                    m_q[i].push_back((dump_base & 32'hFFFF_FFFC) + 32'(4 * k));
                if (dump_count == 8'd0) fin = 1;
                else m_wait[i] = cpu_active && (i == 0);
            end
        end else if (m_q[i].size() > 0) begin
            if (m_wait[i]) begin
                if (!cpu_active) m_wait[i] = 0;
            end else if (dump_ready) begin
                void'(m_q[i].pop_front());
                if (m_q[i].size() == 0) fin = 1;
            end
        end
        m_done[i] = fin;
    endtask

    task automatic compare_outputs(input int i);
        bit          scan;
        logic [31:0] exp_addr;
        scan     = (m_q[i].size() > 0) && !m_wait[i];
        exp_addr = scan ? m_q[i][0] : cpu_address;
        check_output("dump_valid", i, 32'(valid_w[i]), 32'(scan));
        check_output("dump_busy", i, 32'(busy_w[i]), 32'((m_q[i].size() > 0) || m_done[i]));
        check_output("dump_done", i, 32'(done_w[i]), 32'(m_done[i]));
        check_output("cpu_clk_enable", i, 32'(clk_en_w[i]), 32'(!scan));
        check_output("mem_address", i, mem_addr_w[i], exp_addr);
        check_output("mem_read", i, 32'(mem_rd_w[i]), scan ? 32'd1 : 32'(cpu_read));
        check_output("mem_write", i, 32'(mem_wr_w[i]), scan ? 32'd0 : 32'(cpu_write));
        check_output("cpu_readdata", i, cpu_rdata_w[i], ram_word(exp_addr));
        if (!scan) check_output("mem_writedata", i, mem_wdata_w[i], cpu_writedata);
        if (scan) begin
            check_output("dump_addr", i, addr_w[i], m_q[i][0]);
            check_output("dump_data", i, data_w[i], to_big(ram_word(m_q[i][0])));
        end
    endtask

    task automatic apply_stimulus(input logic [31:0] base, input logic [7:0] count);
        dump_base  = base;
        dump_count = count;
        dump_start = 1'b1;
        @(posedge clk); #1;
        dump_start = 1'b0;
    endtask

    initial begin
        reset = 1'b1; cpu_active = 1'b1; cpu_address = 32'h0000_1000; cpu_read = 1'b1;
        cpu_write = 1'b0; cpu_writedata = 32'h1111_2222; dump_start = 1'b0;
        dump_base = '0; dump_count = '0; dump_ready = 1'b1;

        fork
            forever begin
                @(posedge clk);
                for (int i = 0; i < 2; i++) model_step(i);
                if (reset) model_live = 1;
            end
            forever begin
                @(negedge clk);
                if (model_live) for (int i = 0; i < 2; i++) compare_outputs(i);
            end
        join_none

        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_output("reset_clk_en", 0, 32'(clk_en_w[0]), 32'd1);
        check_output("reset_busy", 0, 32'(busy_w[0]), 32'd0);
        check_output("reset_passthru_addr", 0, mem_addr_w[0], 32'h0000_1000);
        check_output("reset_readdata", 0, cpu_rdata_w[0], 32'h1234_4678);

        // CPU runs, halts, then a 29-word dump with ready held high
        @(posedge clk); #1 cpu_address = 32'h0000_1004; cpu_read = 1'b0;
        @(posedge clk); #1 cpu_active = 1'b0;
        @(posedge clk); #1;
        apply_stimulus(32'h0000_0100, 8'd29);
        beats = 0; beats1 = 0; done_at = 0;
        for (int k = 1; k <= 31; k++) begin
            @(negedge clk);
            if (valid_w[0]) beats++;
            if (valid_w[1]) beats1++;
            if (done_w[0] && done_at == 0) done_at = k;
            if (k == 1) begin
                check_output("first_addr", 0, addr_w[0], 32'h0000_0100);
                check_output("first_data", 0, data_w[0], 32'h7857_3412);
            end
            if (k == 29) check_output("last_addr", 0, addr_w[0], 32'h0000_0170);
        end
        check_output("beats29", 0, 32'(beats), 32'd29);
        check_output("beats29", 1, 32'(beats1), 32'd29);
        check_output("done_cycle", 0, 32'(done_at), 32'd30);

        // Ready pattern 1,0,0,1 over a 3-word dump
        pat = '{1, 0, 0, 1, 1, 1, 1, 1};
        @(posedge clk); #1;
        apply_stimulus(32'h0000_0040, 8'd3);
        dump_ready = pat[0];
        acc_n = 0;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            if (valid_w[0] && dump_ready && acc_n < 8) begin
                acc[acc_n] = addr_w[0];
                acc_n++;
            end
            if (k == 2) check_output("stall_addr", 0, addr_w[0], 32'h0000_0044);
            @(posedge clk); #1;
            dump_ready = pat[k + 1];
        end
        check_output("accept_count", 0, 32'(acc_n), 32'd3);
        check_output("accept0", 0, acc[0], 32'h0000_0040);
        check_output("accept1", 0, acc[1], 32'h0000_0044);
        check_output("accept2", 0, acc[2], 32'h0000_0048);

        // Dump requested while the CPU is active: instance 1 preempts, 0 waits
        dump_ready = 1'b1; cpu_active = 1'b1; cpu_write = 1'b1;
        cpu_address = 32'h0000_3000; cpu_writedata = 32'hDEAD_BEEF;
        apply_stimulus(32'h0000_0200, 8'd4);
        lows = 0; v0 = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (!clk_en_w[1]) lows++;
            if (valid_w[0]) v0++;
            if (k == 0) begin
                check_output("preempt_valid", 1, 32'(valid_w[1]), 32'd1);
                check_output("preempt_no_write", 1, 32'(mem_wr_w[1]), 32'd0);
                check_output("wait_busy", 0, 32'(busy_w[0]), 32'd1);
                check_output("wait_write_passes", 0, 32'(mem_wr_w[0]), 32'd1);
            end
        end
        check_output("preempt_stall_cycles", 1, 32'(lows), 32'd4);
        check_output("wait_no_valid", 0, 32'(v0), 32'd0);
        @(posedge clk); #1 cpu_active = 1'b0; cpu_write = 1'b0;
        @(negedge clk);
        check_output("halt_edge_valid", 0, 32'(valid_w[0]), 32'd0);
        @(negedge clk);
        check_output("after_halt_valid", 0, 32'(valid_w[0]), 32'd1);
        check_output("after_halt_addr", 0, addr_w[0], 32'h0000_0200);
        repeat (6) @(negedge clk);

        // Alignment and wrap at the top of the address space
        @(posedge clk); #1;
        apply_stimulus(32'hFFFF_FFFB, 8'd3);
        acc_n = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (valid_w[0] && acc_n < 8) begin
                acc[acc_n] = addr_w[0];
                acc_n++;
            end
            if (k == 0) check_output("wrap_data0", 0, data_w[0], 32'h80A9_CBED);
            if (k == 2) check_output("wrap_data2", 0, data_w[0], 32'h7856_3412);
        end
        check_output("wrap_count", 0, 32'(acc_n), 32'd3);
        check_output("wrap_addr0", 0, acc[0], 32'hFFFF_FFF8);
        check_output("wrap_addr1", 0, acc[1], 32'hFFFF_FFFC);
        check_output("wrap_addr2", 0, acc[2], 32'h0000_0000);
        @(posedge clk); #1;
        apply_stimulus(32'hFFFF_FFF8, 8'd3);
        repeat (5) @(negedge clk);

        // Zero-length dump
        @(posedge clk); #1;
        apply_stimulus(32'h0000_0500, 8'd0);
        @(negedge clk);
        check_output("zero_done", 0, 32'(done_w[0]), 32'd1);
        check_output("zero_done", 1, 32'(done_w[1]), 32'd1);
        check_output("zero_no_valid", 0, 32'(valid_w[0]), 32'd0);
        @(negedge clk);
        check_output("zero_done_clear", 0, 32'(done_w[0]), 32'd0);

        // Reset on beat 5 of a 10-word dump, then a fresh dump
        cpu_address = 32'h0000_5550;
        @(posedge clk); #1;
        apply_stimulus(32'h0000_0300, 8'd10);
        repeat (4) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check_output("beat5_addr", 0, addr_w[0], 32'h0000_0310);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check_output("abort_busy", 0, 32'(busy_w[0]), 32'd0);
        check_output("abort_clk_en", 0, 32'(clk_en_w[0]), 32'd1);
        check_output("abort_passthru", 0, mem_addr_w[0], 32'h0000_5550);
        done_at = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (done_w[0] || done_w[1]) done_at++;
        end
        check_output("abort_no_done", 0, 32'(done_at), 32'd0);
        @(posedge clk); #1;
        apply_stimulus(32'h0000_0080, 8'd2);
        beats = 0; done_at = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (valid_w[0]) beats++;
            if (done_w[0]) done_at++;
        end
        check_output("restart_beats", 0, 32'(beats), 32'd2);
        check_output("restart_done", 0, 32'(done_at), 32'd1);

        @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
